shift_arbiter: RTL and testbench

Shares one 32-bit barrel shifter between two requesters: port 0, the ALU, and port 1, the multdiv/aux unit. Each port has a valid/ready request handshake. Arbitration is round-robin. A single registered response channel carries a port ID tag. The block sits in the execute stage and owns the only shifter instance, so the ALU no longer instantiates its own sll/sra.

---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_core.sv | 71 +++++++
 rtl/shift_arbiter.sv | 122 ++++++++++++
 tb/tb_shift_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the execute-stage shift arbiter: op encodings,
// default data/amount widths and requester port IDs.
package shift_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AMT_W = 5;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage : shift_pkg

// File: rtl/shift_core.sv
// Combinational barrel shifter: log2(WIDTH) mux stages, each stage moving
// the data by a power of two when the matching amount bit is set.
// Configuration macro: SHIFT_ARB_SRL_EN -- when defined, op 10 is a logical
// right shift; when undefined, op 10 decodes as an arithmetic right shift and
// the right-shift fill is always the sign bit.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] out_o
);

  logic             left_s;
  logic             fill_s;
  logic [AMT_W-1:0] amt_eff_s;
  logic [WIDTH-1:0] cur_s;
  logic signed [WIDTH:0] wide_s;

  // Decode the op into direction, right-shift fill bit and effective amount
  always_comb begin
    left_s    = 1'b0;
    fill_s    = 1'b0;
    amt_eff_s = amt_i;
    case (op_i)
      OP_SLL: begin
        left_s = 1'b1;
      end
      OP_SRA: begin
        fill_s = in_i[WIDTH-1];
      end
      OP_SRL: begin
`ifdef SHIFT_ARB_SRL_EN
        fill_s = 1'b0;
`else
        fill_s = in_i[WIDTH-1];
`endif
      end
      OP_PASS: begin
        amt_eff_s = {AMT_W{1'b0}};
      end
      default: begin
        amt_eff_s = {AMT_W{1'b0}};
      end
    endcase
  end

  // Mux stages: stage k shifts by 2**k when amount bit k is set
  always_comb begin
    cur_s  = in_i;
    wide_s = {(WIDTH+1){1'b0}};
    for (int k = 0; k < AMT_W; k++) begin
      if (amt_eff_s[k]) begin
        if (left_s) begin
          cur_s = cur_s << (32'd1 << k);
        end else begin
          wide_s = $signed({fill_s, cur_s}) >>> (32'd1 << k);
          cur_s  = wide_s[WIDTH-1:0];
        end
      end else begin
        cur_s = cur_s;
      end
    end
    out_o = cur_s;
  end

endmodule : shift_core

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between the ALU (port 0)
// and the multdiv/aux unit (port 1), with a single registered response
// channel tagged by port ID.
// Configuration macro: SHIFT_ARB_SRL_EN (forwarded to shift_core; enables
// a true logical right shift for op 10).
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_in,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_in,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_id
);

  logic             free_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             accept0_s;
  logic             accept1_s;
  logic [WIDTH-1:0] sel_in_s;
  logic [AMT_W-1:0] sel_amt_s;
  logic [1:0]       sel_op_s;
  logic [WIDTH-1:0] shift_out_s;

  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_out_q,   resp_out_d;
  logic             resp_id_q,    resp_id_d;
  logic             rr_q,         rr_d;

  // Grant: a lone requester wins; under contention the rr pointer decides
  always_comb begin
    free_s = ~resp_valid_q | resp_ready;
    if (req0_valid & req1_valid) begin
      grant0_s = (rr_q == PORT_ALU);
      grant1_s = (rr_q == PORT_AUX);
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  assign req0_ready = grant0_s & free_s & ~reset;
  assign req1_ready = grant1_s & free_s & ~reset;
  assign accept0_s  = req0_valid & req0_ready;
  assign accept1_s  = req1_valid & req1_ready;

  // Steer the granted port's payload into the shared shifter
  always_comb begin
    if (grant1_s) begin
      sel_in_s  = req1_in;
      sel_amt_s = req1_amt;
      sel_op_s  = req1_op;
    end else begin
      sel_in_s  = req0_in;
      sel_amt_s = req0_amt;
      sel_op_s  = req0_op;
    end
  end

  shift_core #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_core (
    .in_i  (sel_in_s),
    .amt_i (sel_amt_s),
    .op_i  (sel_op_s),
    .out_o (shift_out_s)
  );

  // Response register next state: load on accept, clear valid on drain
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_out_d   = resp_out_q;
    resp_id_d    = resp_id_q;
    rr_d         = rr_q;
    if (accept0_s | accept1_s) begin
      resp_valid_d = 1'b1;
      resp_out_d   = shift_out_s;
      resp_id_d    = accept1_s ? PORT_AUX : PORT_ALU;
      rr_d         = accept1_s ? PORT_ALU : PORT_AUX;
    end else if (resp_valid_q & resp_ready) begin
      resp_valid_d = 1'b0;
    end else begin
      resp_valid_d = resp_valid_q;
    end
  end

  // State registers with synchronous reset; rr restarts favouring port 0
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_out_q   <= {WIDTH{1'b0}};
      resp_id_q    <= PORT_ALU;
      rr_q         <= PORT_ALU;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_out_q   <= resp_out_d;
      resp_id_q    <= resp_id_d;
      rr_q         <= rr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_out   = resp_out_q;
  assign resp_id    = resp_id_q;

endmodule : shift_arbiter

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed cases with hand-computed
// results, then randomized traffic checked every cycle against a
// behavioural model of the arbitration and shift rules.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_in, req1_in;
  logic [4:0]  req0_amt, req1_amt;
  logic [1:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_out;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit        m_valid = 1'b0;
  bit [31:0] m_out   = 32'h0;
  bit        m_id    = 1'b0;
  bit        m_rr    = 1'b0;
  bit        last_acc0, last_acc1;

  shift_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in    (req0_in),
    .req0_amt   (req0_amt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in    (req1_in),
    .req1_amt   (req1_amt),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .resp_id    (resp_id)
  );

  always #5 clock = ~clock;

  function automatic bit [31:0] ref_shift(input bit [31:0] x, input bit [4:0] amt, input bit [1:0] op);
    bit signed [31:0] sx;
    sx = x;
    case (op)
      2'b00:   return x << amt;
      2'b01:   return sx >>> amt;
`ifdef SHIFT_ARB_SRL_EN
      2'b10:   return x >> amt;
`else
      2'b10:   return sx >>> amt;
`endif
      default: return x;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven (at a negedge). Compare the
  // DUT to the model, advance the model at the posedge, return at negedge.
  task automatic step();
    bit e_rdy0, e_rdy1, free, win0;
    #1;
    free = !m_valid || resp_ready;
    if (req0_valid && req1_valid) win0 = (m_rr == 1'b0);
    else                          win0 = req0_valid;
    e_rdy0 = !reset && free && req0_valid && win0;
    e_rdy1 = !reset && free && req1_valid && !win0;
    check("req0_ready", {31'd0, req0_ready}, {31'd0, e_rdy0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, e_rdy1});
    check("resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("resp_out", resp_out, m_out);
      check("resp_id", {31'd0, resp_id}, {31'd0, m_id});
    end
    last_acc0 = e_rdy0;
    last_acc1 = e_rdy1;
    @(posedge clock);
    if (reset) begin
      m_valid = 1'b0; m_out = 32'h0; m_id = 1'b0; m_rr = 1'b0;
      last_acc0 = 1'b0; last_acc1 = 1'b0;
    end else if (last_acc0 || last_acc1) begin
      m_valid = 1'b1;
      m_id    = last_acc1;
      m_out   = last_acc1 ? ref_shift(req1_in, req1_amt, req1_op)
                          : ref_shift(req0_in, req0_amt, req0_op);
      m_rr    = !last_acc1;
    end else if (m_valid && resp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic set0(input bit v, input bit [31:0] x, input bit [4:0] a, input bit [1:0] o);
    req0_valid = v; req0_in = x; req0_amt = a; req0_op = o;
  endtask

  task automatic set1(input bit v, input bit [31:0] x, input bit [4:0] a, input bit [1:0] o);
    req1_valid = v; req1_in = x; req1_amt = a; req1_op = o;
  endtask

  initial begin
    bit [31:0] exp_srl;
    reset = 1'b1;
    resp_ready = 1'b1;
    set0(1'b1, 32'h0, 5'd0, 2'b00);
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    @(posedge clock);
    @(negedge clock);

    // reset state, readies held low while reset is asserted
    step();
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_out", resp_out, 32'h0);
    check("rst_id", {31'd0, resp_id}, 32'd0);
    #1 check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    reset = 1'b0;

    // single request on port 0
    set0(1'b1, 32'h02E04608, 5'd7, 2'b01);
    step();
    set0(1'b0, 32'h0, 5'd0, 2'b00);
    check("p0_sra_out", resp_out, 32'h0005C08C);
    check("p0_sra_id", {31'd0, resp_id}, 32'd0);
    check("p0_sra_valid", {31'd0, resp_valid}, 32'd1);

    // port 1 sign fill and op 10
    set1(1'b1, 32'h80000000, 5'd4, 2'b01);
    step();
    check("p1_sra_out", resp_out, 32'hF8000000);
    check("p1_sra_id", {31'd0, resp_id}, 32'd1);
    set1(1'b1, 32'h80000000, 5'd4, 2'b10);
    step();
`ifdef SHIFT_ARB_SRL_EN
    exp_srl = 32'h08000000;
`else
    exp_srl = 32'hF8000000;
`endif
    check("p1_op10_out", resp_out, exp_srl);
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    step();

    // contention after reset: 0,1,0,1
    reset = 1'b1;
    step();
    reset = 1'b0;
    set0(1'b1, 32'h02E04608, 5'd3, 2'b01);
    set1(1'b1, 32'h00000001, 5'd31, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont_id", {31'd0, resp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("cont_out", resp_out, (i % 2 == 0) ? 32'h005C08C1 : 32'h80000000);
    end

    // backpressure for 3 cycles, then release accepts port 0 the same cycle
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_out", resp_out, 32'h80000000);
      check("bp_id", {31'd0, resp_id}, 32'd1);
    end
    resp_ready = 1'b1;
    step();
    check("bp_rel_id", {31'd0, resp_id}, 32'd0);
    check("bp_rel_out", resp_out, 32'h005C08C1);

    // amount 0 and pass-through
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    set0(1'b1, 32'hDEADBEEF, 5'd0, 2'b01);
    step();
    check("amt0_out", resp_out, 32'hDEADBEEF);
    resp_ready = 1'b0;
    set0(1'b1, 32'h12345678, 5'd9, 2'b11);
    step();
    check("pass_out", resp_out, 32'hDEADBEEF);
    resp_ready = 1'b1;
    step();
    check("pass_out2", resp_out, 32'h12345678);

    // reset while a result is pending; port 0 must win first afterwards
    resp_ready = 1'b0;
    set1(1'b1, 32'h00000010, 5'd1, 2'b00);
    reset = 1'b1;
    step();
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_out", resp_out, 32'h0);
    reset = 1'b0;
    resp_ready = 1'b1;
    step();
    check("post_rst_id", {31'd0, resp_id}, 32'd0);
    check("post_rst_out", resp_out, 32'h12345678);

    // randomized traffic obeying the requester hold rule
    set0(1'b0, 32'h0, 5'd0, 2'b00);
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid && $urandom_range(0, 1) == 1)
        set0(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      if (!req1_valid && $urandom_range(0, 1) == 1)
        set1(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      step();
      if (last_acc0)
        set0(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      if (last_acc1)
        set1(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_shift_arbiter
